vproc_mem_arb_model: RTL and testbench

//  Synthesisable multi-port memory model with a fixed-latency response pipeline and round-robin arbitration.

---
 rtl/vproc_mem_arb_model_pkg.sv | 15 +
 rtl/vproc_mem_arb_model_lat_pipe.sv | 40 ++++
 rtl/vproc_mem_arb_model.sv | 136 +++++++++++++
 tb/tb_vproc_mem_arb_model.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_mem_arb_model_pkg.sv
// Shared helpers for the multi-port memory model.
// Holds the address range check used by the request decoder.
package vproc_mem_arb_model_pkg;

  // True when a byte address falls outside [base, base+size).
  // off wraps modulo 2^32, so addresses below base are caught explicitly.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] size);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (off >= size);
  endfunction

endpackage

// File: rtl/vproc_mem_arb_model_lat_pipe.sv
// Fixed-depth response shift register for the memory model.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset; clears only the valid bits
//   in_i    response entering stage 0 (T must carry a 'vld' field)
//   out_o   response leaving the last stage
module vproc_mem_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  T     in_i,
  output T     out_o
);

  logic r_vld [DEPTH];
  T     r_pay [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= in_i.vld;
      for (int unsigned i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Payload is never reset; the separately cleared valid chain qualifies it.
  always_ff @(posedge clk_i) begin
    r_pay[0] <= in_i;
    for (int unsigned i = 1; i < DEPTH; i++) r_pay[i] <= r_pay[i-1];
  end

  always_comb begin
    out_o     = r_pay[DEPTH-1];
    out_o.vld = r_vld[DEPTH-1];
  end

endmodule

// File: rtl/vproc_mem_arb_model.sv
// Multi-port memory model: round-robin arbiter, base/range decode, byte-enable
// word array and a fixed-latency response pipeline demuxed back to the ports.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_i/gnt_o [N_PORTS]         request (held until grant) / one-hot grant
//   addr_i [N_PORTS*32]           byte addresses
//   we_i, be_i, wdata_i           write enable, byte enables, write data
//   rvalid_o, err_o, rdata_o      per-port response pulse, error, read data
module vproc_mem_arb_model
  import vproc_mem_arb_model_pkg::*;
#(
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned MEM_SZ      = 262144,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_PORTS-1:0]             req_i,
  output logic [N_PORTS-1:0]             gnt_o,
  input  logic [N_PORTS*32-1:0]          addr_i,
  input  logic [N_PORTS-1:0]             we_i,
  input  logic [N_PORTS*(MEM_W/8)-1:0]   be_i,
  input  logic [N_PORTS*MEM_W-1:0]       wdata_i,
  output logic [N_PORTS-1:0]             rvalid_o,
  output logic [N_PORTS-1:0]             err_o,
  output logic [N_PORTS*MEM_W-1:0]       rdata_o
);

  localparam int unsigned BYTES   = MEM_W / 8;
  localparam int unsigned OFF_LSB = $clog2(BYTES);
  localparam int unsigned AW      = $clog2(MEM_SZ);
  localparam int unsigned IW      = AW - OFF_LSB;
  localparam int unsigned WORDS   = MEM_SZ / BYTES;
  localparam int unsigned PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef struct packed {
    logic             vld;
    logic [PW-1:0]    port;
    logic             err;
    logic [MEM_W-1:0] rdata;
  } mem_rsp_t;

  logic [PW-1:0]    r_ptr;      // port where the next grant search starts
  logic [N_PORTS-1:0] w_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_any;
  logic [31:0]      w_addr;
  logic [31:0]      w_off;
  logic             w_we;
  logic [BYTES-1:0] w_be;
  logic [MEM_W-1:0] w_wdata;
  logic             w_err;
  logic [IW-1:0]    w_widx;
  mem_rsp_t         w_rsp_in;
  mem_rsp_t         w_rsp_out;

  logic [MEM_W-1:0] r_mem [WORDS];

  // First requester at or after r_ptr wins; nothing is granted in reset.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      int unsigned p;
      p = (32'(r_ptr) + k) % N_PORTS;
      if (!w_any && req_i[p]) begin
        w_gnt[p]  = 1'b1;
        w_gnt_idx = PW'(p);
        w_any     = 1'b1;
      end
    end
    if (!rst_ni) begin
      w_gnt = '0;
      w_any = 1'b0;
    end
  end

  assign gnt_o = w_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= '0;
    else if (w_any) r_ptr <= PW'((32'(w_gnt_idx) + 1) % N_PORTS);
  end

  always_comb begin
    w_addr  = addr_i[w_gnt_idx*32 +: 32];
    w_we    = we_i[w_gnt_idx];
    w_be    = be_i[w_gnt_idx*BYTES +: BYTES];
    w_wdata = wdata_i[w_gnt_idx*MEM_W +: MEM_W];
    w_off   = w_addr - BASE_ADDR;
    w_err   = addr_out_of_range(w_addr, BASE_ADDR, 32'(MEM_SZ));
    w_widx  = IW'(w_off >> OFF_LSB);
  end

  always_ff @(posedge clk_i) begin
    if (w_any && w_we && !w_err) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_be[b]) r_mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_rsp_in.vld   = w_any;
    w_rsp_in.port  = w_gnt_idx;
    w_rsp_in.err   = w_err;
    w_rsp_in.rdata = (w_any && !w_we && !w_err) ? r_mem[w_widx] : '0;
  end

  vproc_mem_lat_pipe #(
    .DEPTH (MEM_LATENCY),
    .T     (mem_rsp_t)
  ) u_lat_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (w_rsp_in),
    .out_o  (w_rsp_out)
  );

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (w_rsp_out.vld && (32'(w_rsp_out.port) == p)) begin
        rvalid_o[p]                = 1'b1;
        err_o[p]                   = w_rsp_out.err;
        rdata_o[p*MEM_W +: MEM_W]  = w_rsp_out.rdata;
      end
    end
  end

endmodule

// File: tb/tb_vproc_mem_arb_model.sv
module tb_vproc_mem_arb_model;

  localparam int unsigned NP    = 2;
  localparam int unsigned SZ    = 262144;
  localparam int unsigned SZB   = 4096;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic [NP-1:0]    req_a, gnt_a, we_a, rv_a, er_a;
  logic [NP*32-1:0] addr_a, wd_a, rd_a;
  logic [NP*4-1:0]  be_a;
  logic [NP-1:0]    req_b, gnt_b, we_b, rv_b, er_b;
  logic [NP*32-1:0] addr_b, wd_b, rd_b;
  logic [NP*4-1:0]  be_b;

  vproc_mem_arb_model #(.N_PORTS(NP), .MEM_W(32), .MEM_SZ(SZ), .BASE_ADDR(BASE), .MEM_LATENCY(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a), .we_i(we_a),
    .be_i(be_a), .wdata_i(wd_a), .rvalid_o(rv_a), .err_o(er_a), .rdata_o(rd_a));

  vproc_mem_arb_model #(.N_PORTS(NP), .MEM_W(32), .MEM_SZ(SZB), .BASE_ADDR(BASE), .MEM_LATENCY(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b), .we_i(we_b),
    .be_i(be_b), .wdata_i(wd_b), .rvalid_o(rv_b), .err_o(er_b), .rdata_o(rd_b));

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model for instance A ----------------
  typedef struct {
    longint      due;
    int          port;
    bit          err;
    logic [31:0] rd;
    bit          known;
  } exp_t;

  exp_t        q_a[$];
  logic [7:0]  m_mem [int];
  int unsigned nxt_a  = 0;
  longint      cyc_a  = 0;
  bit          mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [NP-1:0] eg, erv;
      int            gp;
      exp_t          e;
      logic [31:0]   ad, off;
      int            wi;
      eg = '0; erv = '0; gp = -1;
      for (int k = 0; k < NP; k++)
        if (gp < 0 && req_a[(nxt_a + k) % NP]) gp = int'((nxt_a + k) % NP);
      if (gp >= 0) eg[gp] = 1'b1;
      chk("arb_gnt", gnt_a, eg);
      if (q_a.size() > 0 && q_a[0].due == cyc_a) begin
        e = q_a.pop_front();
        erv[e.port] = 1'b1;
        chk("rsp_err", er_a[e.port], e.err);
        if (e.known) chk("rsp_rdata", rd_a[e.port*32 +: 32], e.rd);
      end
      chk("rsp_valid", rv_a, erv);
      if (gp >= 0) begin
        ad = addr_a[gp*32 +: 32];
        off = ad - BASE;
        e.due = cyc_a + LAT_A; e.port = gp; e.rd = '0; e.known = 1'b1;
        e.err = (ad < BASE) || (off >= SZ);
        if (!e.err) begin
          wi = int'(off / 4);
          for (int b = 0; b < 4; b++) begin
            if (we_a[gp]) begin
              if (be_a[gp*4 + b]) m_mem[wi*4 + b] = wd_a[gp*32 + b*8 +: 8];
            end else if (m_mem.exists(wi*4 + b)) e.rd[b*8 +: 8] = m_mem[wi*4 + b];
            else e.known = 1'b0;
          end
        end
        q_a.push_back(e);
        nxt_a = (gp + 1) % NP;
      end
      cyc_a++;
    end
  end

  longint cycb = 0;
  always @(posedge clk) cycb++;

  // One complete transaction on instance A (s=0) or B (s=1), port p.
  task automatic txn(input bit s, input int p, input bit we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd,
                     output bit err, output logic [31:0] rd);
    bit ok;
    ok = 0; err = 0; rd = '0;
    @(posedge clk); #1;
    if (s) begin
      req_b[p] = 1; we_b[p] = we; addr_b[p*32 +: 32] = addr; be_b[p*4 +: 4] = be; wd_b[p*32 +: 32] = wd;
    end else begin
      req_a[p] = 1; we_a[p] = we; addr_a[p*32 +: 32] = addr; be_a[p*4 +: 4] = be; wd_a[p*32 +: 32] = wd;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = s ? gnt_b[p] : gnt_a[p];
    end
    @(posedge clk); #1;
    if (s) req_b[p] = 0; else req_a[p] = 0;
    chk("txn_grant_seen", ok, 1);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s ? rv_b[p] : rv_a[p]) begin
        ok = 1;
        err = s ? er_b[p] : er_a[p];
        rd  = s ? rd_b[p*32 +: 32] : rd_a[p*32 +: 32];
      end
    end
    chk("txn_rsp_seen", ok, 1);
  endtask

  task automatic rnd_port(input int p, input int n);
    bit ok;
    int sel;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      sel = $urandom_range(0, 7);
      req_a[p] = 1;
      we_a[p]  = $urandom_range(0, 1);
      be_a[p*4 +: 4]   = 4'($urandom);
      wd_a[p*32 +: 32] = $urandom;
      if (sel == 0) addr_a[p*32 +: 32] = BASE - 32'd4;
      else if (sel == 1) addr_a[p*32 +: 32] = BASE + SZ;
      else addr_a[p*32 +: 32] = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = gnt_a[p];
      end
      chk("rnd_grant_seen", ok, 1);
      @(posedge clk); #1;
      req_a[p] = 0;
      addr_a[p*32 +: 32] = 'x;
    end
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          e;
    logic [31:0] r;
    int          first, ng, nr;
    logic [1:0]  g3[6];
    int          rp[6];
    logic [31:0] rdv[6];
    longint      t0, gc[5], rc[5];
    logic [31:0] v[5];

    vt[0]  = '{0, 1, BASE,               4'hF, 32'hDEADBEEF, 0, 32'h0};
    vt[1]  = '{0, 0, BASE,               4'hF, 32'h0,        0, 32'hDEADBEEF};
    vt[2]  = '{1, 1, BASE + 4,           4'hF, 32'h11223344, 0, 32'h0};
    vt[3]  = '{0, 1, BASE + 4,           4'h2, 32'h0000AB00, 0, 32'h0};
    vt[4]  = '{1, 0, BASE + 4,           4'hF, 32'h0,        0, 32'h1122AB44};
    vt[5]  = '{0, 0, BASE + 6,           4'hF, 32'h0,        0, 32'h1122AB44};
    vt[6]  = '{1, 1, BASE + 8,           4'hF, 32'h0,        0, 32'h0};
    vt[7]  = '{1, 1, BASE + 8,           4'h9, 32'hAABBCCDD, 0, 32'h0};
    vt[8]  = '{0, 0, BASE + 8,           4'hF, 32'h0,        0, 32'hAA0000DD};
    vt[9]  = '{0, 1, BASE + SZ - 4,      4'hF, 32'h5A5A5A5A, 0, 32'h0};
    vt[10] = '{1, 0, 32'h0000_1FFC,      4'hF, 32'h0,        1, 32'h0};
    vt[11] = '{0, 0, BASE + SZ,          4'hF, 32'h0,        1, 32'h0};
    vt[12] = '{1, 1, 32'h0000_1FFC,      4'hF, 32'hFFFFFFFF, 1, 32'h0};
    vt[13] = '{0, 0, BASE + SZ - 4,      4'hF, 32'h0,        0, 32'h5A5A5A5A};
    vt[14] = '{1, 0, 32'hFFFF_FFFC,      4'hF, 32'h0,        1, 32'h0};
    vt[15] = '{0, 0, BASE,               4'hF, 32'h0,        0, 32'hDEADBEEF};

    rst_a = 0; rst_b = 0;
    req_a = 2'b11; we_a = '0; be_a = '1; wd_a = '0; addr_a = {BASE + 4, BASE};
    req_b = '0;    we_b = '0; be_b = '1; wd_b = '0; addr_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_rvalid_a", rv_a, 0);
    chk("rst_err_a", er_a, 0);
    chk("rst_rdata_a", rd_a, 0);
    chk("rst_rvalid_b", rv_b, 0);
    chk("rst_rdata_b", rd_b, 0);
    req_a = '0;
    @(posedge clk); #1;
    rst_a = 1; rst_b = 1;
    mon_en = 1;

    // table-driven single transactions
    for (int i = 0; i < 16; i++) begin
      txn(0, vt[i].port, vt[i].we, vt[i].addr, vt[i].be, vt[i].wd, e, r);
      chk($sformatf("vec%0d_err", i), e, vt[i].eerr);
      chk($sformatf("vec%0d_rdata", i), r, vt[i].erd);
    end

    // both ports request every cycle: grants alternate, responses routed in order
    @(posedge clk); #1;
    first = int'(nxt_a);
    we_a = '0; addr_a = {BASE + 4, BASE}; req_a = 2'b11;
    ng = 0; nr = 0;
    for (int i = 0; i < 6; i++) begin g3[i] = '0; rp[i] = -1; rdv[i] = '0; end
    for (int c = 0; c < 20 && nr < 6; c++) begin
      @(negedge clk);
      if (rv_a != 0 && nr < 6) begin
        rp[nr]  = rv_a[1] ? 1 : 0;
        rdv[nr] = rv_a[1] ? rd_a[63:32] : rd_a[31:0];
        nr++;
      end
      if (ng < 6 && gnt_a != 0) begin g3[ng] = gnt_a; ng++; end
      @(posedge clk); #1;
      if (ng >= 6) req_a = '0;
    end
    req_a = '0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), g3[i], 2'b01 << ((first + i) % 2));
      chk($sformatf("rr_rsp_port%0d", i), rp[i], (first + i) % 2);
      chk($sformatf("rr_rsp_data%0d", i), rdv[i], ((first + i) % 2 == 0) ? 32'hDEADBEEF : 32'h1122AB44);
    end

    // randomized contention, checked by the model
    fork
      rnd_port(0, 40);
      rnd_port(1, 40);
    join
    repeat (LAT_A + 4) @(posedge clk);
    chk("drain_queue_empty", q_a.size(), 0);
    mon_en = 0;

    // instance B (latency 3): single port, request held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      v[i] = 32'hC0DE_0000 + 32'(i * 17);
      txn(1, 0, 1, BASE + 32'(4 * i), 4'hF, v[i], e, r);
      chk("t6_prewrite_err", e, 0);
    end
    @(posedge clk); #1;
    t0 = cycb;
    req_b[0] = 1; we_b[0] = 0; addr_b[31:0] = BASE;
    ng = 0; nr = 0;
    for (int i = 0; i < 5; i++) begin gc[i] = -1; rc[i] = -1; rdv[i] = '0; end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rv_b[0] && nr < 5) begin rc[nr] = cycb; rdv[nr] = rd_b[31:0]; nr++; end
      if (ng < 5 && gnt_b[0]) begin gc[ng] = cycb; ng++; end
      @(posedge clk); #1;
      if (ng < 5) addr_b[31:0] = BASE + 32'(4 * ng);
      else req_b[0] = 0;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6_grant_cycle%0d", i), gc[i], t0 + i);
      chk($sformatf("t6_rvalid_cycle%0d", i), rc[i], t0 + i + LAT_B);
      chk($sformatf("t6_rdata%0d", i), rdv[i], v[i]);
    end

    // instance B: reset after the second grant drops in-flight responses
    @(posedge clk); #1;
    req_b[0] = 1; we_b[0] = 0; addr_b[31:0] = BASE;
    ng = 0;
    for (int c = 0; c < 10 && ng < 2; c++) begin
      @(negedge clk);
      if (gnt_b[0]) ng++;
      @(posedge clk); #1;
      addr_b[31:0] = BASE + 32'(4 * ng);
    end
    rst_b = 0;
    chk("t5_grants_before_reset", ng, 2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_rvalid_in_reset", rv_b, 0);
      chk("t5_gnt_in_reset", gnt_b, 0);
      chk("t5_rdata_in_reset", rd_b, 0);
    end
    @(posedge clk); #1;
    req_b[0] = 0; rst_b = 1;
    for (int c = 0; c < LAT_B + 3; c++) begin
      @(negedge clk);
      chk("t5_rvalid_after_reset", rv_b, 0);
    end
    txn(1, 0, 0, BASE + 8, 4'hF, 32'h0, e, r);
    chk("t5_new_read_err", e, 0);
    chk("t5_new_read_rdata", r, v[2]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
